// File: rtl/rv32i_pkg.sv
// Shared RV32I opcode, instruction-class and fault definitions used by the
// fetch unit and the downstream per-format control decoders.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] CLS_LUI     = 4'd0;
    localparam logic [3:0] CLS_AUIPC   = 4'd1;
    localparam logic [3:0] CLS_JAL     = 4'd2;
    localparam logic [3:0] CLS_JALR    = 4'd3;
    localparam logic [3:0] CLS_BRANCH  = 4'd4;
    localparam logic [3:0] CLS_LOAD    = 4'd5;
    localparam logic [3:0] CLS_STORE   = 4'd6;
    localparam logic [3:0] CLS_IMM     = 4'd7;
    localparam logic [3:0] CLS_REG     = 4'd8;
    localparam logic [3:0] CLS_SYSTEM  = 4'd9;
    localparam logic [3:0] CLS_ILLEGAL = 4'hF;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/insn_predecode.sv
// Combinational opcode -> instruction class lookup; anything not listed,
// including opcodes with bits [1:0] != 2'b11, is ILLEGAL.
module insn_predecode
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] insn_class
);

    always_comb begin
        insn_class = CLS_ILLEGAL;
        case (opcode)
            OP_LUI:    insn_class = CLS_LUI;
            OP_AUIPC:  insn_class = CLS_AUIPC;
            OP_JAL:    insn_class = CLS_JAL;
            OP_JALR:   insn_class = CLS_JALR;
            OP_BRANCH: insn_class = CLS_BRANCH;
            OP_LOAD:   insn_class = CLS_LOAD;
            OP_STORE:  insn_class = CLS_STORE;
            OP_IMM:    insn_class = CLS_IMM;
            OP_REG:    insn_class = CLS_REG;
            OP_SYSTEM: insn_class = CLS_SYSTEM;
            default:   insn_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/insn_fetch_unit.sv
// Multi-cycle fetch/hold stage: owns the PC, fetches via req/ack and holds INSN
// through execute. Define FETCH_TIMEOUT_EN to halt on a stuck memory ack.
module insn_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] INSN,
    output logic        insn_valid,
    output logic [3:0]  insn_class,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        exec_done,
    input  logic        stall,
    output logic        halted,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_EXEC = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] fetch_class;

    // The incoming word is classified before it is latched so an illegal
    // opcode can go straight to HALT without ever raising insn_valid.
    insn_predecode u_fetch_dec (.opcode(mem_rdata[6:0]), .insn_class(fetch_class));
    insn_predecode u_insn_dec  (.opcode(INSN[6:0]),      .insn_class(insn_class));

    // Gated by RST so the request drops the instant reset rises.
    assign mem_req  = (state == S_REQ) && !RST;
    assign mem_addr = pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] wait_cnt;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            INSN       <= NOP;
            insn_valid <= 1'b0;
            halted     <= 1'b0;
            fault      <= FAULT_NONE;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt   <= 8'd0;
`endif
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_ack) begin
                        INSN <= mem_rdata;
                        if (fetch_class == CLS_ILLEGAL) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                            fault  <= FAULT_ILLEGAL;
                        end else begin
                            state      <= S_EXEC;
                            insn_valid <= 1'b1;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_cnt + 8'd1 == TIMEOUT_LIMIT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                        fault  <= FAULT_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                S_EXEC: begin
                    if (exec_done && !stall) begin
                        insn_valid <= 1'b0;
                        if (pc_next[1:0] != 2'b00) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                            fault  <= FAULT_MISALIGN;
                        end else begin
                            pc    <= pc_next;
                            state <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                            wait_cnt <= 8'd0;
`endif
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state      <= S_HALT;
                    halted     <= 1'b1;
                    insn_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Self-checking bench for insn_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_insn_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] INSN;
    logic        insn_valid;
    logic [3:0]  insn_class;
    logic [31:0] pc;
    logic [31:0] pc_next = 32'h0;
    logic        exec_done = 1'b0;
    logic        stall = 1'b0;
    logic        halted;
    logic [1:0]  fault;

    insn_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .INSN(INSN),
        .insn_valid(insn_valid), .insn_class(insn_class), .pc(pc),
        .pc_next(pc_next), .exec_done(exec_done), .stall(stall),
        .halted(halted), .fault(fault)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                             7'b0110011, 7'b1110011};

    function automatic logic [3:0] cls_of(input logic [6:0] op);
        for (int i = 0; i < 10; i++)
            if (op == ops[i]) return 4'(i);
        return 4'hF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetching / executing / stopped.
    logic [31:0] m_pc, m_insn;
    bit          m_exec, m_halt;
    logic [1:0]  m_fault;
    int          m_wait;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_pc <= RESET_PC; m_insn <= 32'h13; m_exec <= 0; m_halt <= 0;
            m_fault <= 0; m_wait <= 0;
        end else if (!m_halt) begin
            if (!m_exec) begin
                if (mem_ack) begin
                    m_insn <= mem_rdata;
                    if (cls_of(mem_rdata[6:0]) == 4'hF) begin
                        m_halt <= 1; m_fault <= 1;
                    end else m_exec <= 1;
                end else begin
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait + 1 == TIMEOUT) begin
                        m_halt <= 1; m_fault <= 3;
                    end else m_wait <= m_wait + 1;
`endif
                end
            end else if (exec_done && !stall) begin
                m_exec <= 0;
                if (pc_next % 4 != 0) begin
                    m_halt <= 1; m_fault <= 2;
                end else begin
                    m_pc <= pc_next; m_wait <= 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            bit exp_req;
            exp_req = !RST && !m_exec && !m_halt;
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) check("mem_addr", mem_addr, m_pc);
            check("insn_valid", 32'(insn_valid), 32'(m_exec));
            check("INSN", INSN, m_insn);
            check("pc", pc, m_pc);
            check("halted", 32'(halted), 32'(m_halt));
            check("fault", 32'(fault), 32'(m_fault));
            if (m_exec) check("insn_class", 32'(insn_class), 32'(cls_of(m_insn[6:0])));
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        mem_ack = 0; exec_done = 0; stall = 0;
        tick(); RST = 1;
        tick(); RST = 0;
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;

        do_reset();
        chk_en = 1;
        check("reset_pc", pc, RESET_PC);
        check("reset_insn", INSN, 32'h13);
        check("reset_valid", 32'(insn_valid), 32'd0);

        // Immediate ack of a NOP
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        #1 check("first_addr", mem_addr, 32'h0);
        check("first_req", 32'(mem_req), 32'd1);
        tick(); mem_ack = 0;
        check("first_valid", 32'(insn_valid), 32'd1);
        check("first_insn", INSN, 32'h13);
        check("first_class", 32'(insn_class), 32'd7);

        // Next fetch with ack delayed 3 cycles
        exec_done = 1; pc_next = 32'h4;
        tick(); exec_done = 0; mem_rdata = 32'h0000_80E7;
        for (int i = 0; i < 3; i++) begin
            check("dly_req", 32'(mem_req), 32'd1);
            check("dly_addr", mem_addr, 32'h4);
            tick();
        end
        check("dly_insn_held", INSN, 32'h13);
        mem_ack = 1;
        check("dly_req4", 32'(mem_req), 32'd1);
        tick(); mem_ack = 0;
        check("jalr_insn", INSN, 32'h0000_80E7);
        check("jalr_class", 32'(insn_class), 32'd3);

        // Stall beats exec_done for two cycles
        exec_done = 1; stall = 1; pc_next = 32'h100;
        tick(); check("stall_pc1", pc, 32'h4);
        tick(); check("stall_pc2", pc, 32'h4);
        stall = 0;
        tick(); exec_done = 0;
        check("jump_pc", pc, 32'h100);
        check("jump_addr", mem_addr, 32'h100);
        check("jump_req", 32'(mem_req), 32'd1);

        // Misaligned pc_next halts
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        tick(); mem_ack = 0;
        exec_done = 1; pc_next = 32'h102;
        tick(); exec_done = 0;
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_fault", 32'(fault), 32'd2);
        check("mis_pc", pc, 32'h100);
        mem_ack = 1;
        repeat (10) tick();
        mem_ack = 0;
        check("mis_req_low", 32'(mem_req), 32'd0);

        // Illegal opcode
        do_reset();
        mem_ack = 1; mem_rdata = 32'h0000_0000;
        tick(); mem_ack = 0;
        check("ill_fault", 32'(fault), 32'd1);
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_valid", 32'(insn_valid), 32'd0);
        repeat (3) tick();

        // Reset pulse between edges during REQ
        do_reset();
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        tick(); mem_ack = 0; exec_done = 1; pc_next = 32'h40;
        tick(); exec_done = 0;
        check("pre_pulse_addr", mem_addr, 32'h40);
        RST = 1;
        #1 check("pulse_req", 32'(mem_req), 32'd0);
        #1 RST = 0;
        #1 check("pulse_pc", pc, RESET_PC);
        check("pulse_req_back", 32'(mem_req), 32'd1);

        // No ack at all
        do_reset();
        repeat (TIMEOUT - 1) tick();
        check("to_not_yet", 32'(halted), 32'd0);
        tick();
`ifdef FETCH_TIMEOUT_EN
        check("to_halted", 32'(halted), 32'd1);
        check("to_fault", 32'(fault), 32'd3);
`else
        repeat (8) tick();
        check("to_still_req", 32'(mem_req), 32'd1);
        check("to_no_fault", 32'(fault), 32'd0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            if (m_halt) do_reset();
            r  = $urandom();
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 24) == 0) op = 7'($urandom());
            mem_rdata = {r[31:7], op};
            mem_ack   = ($urandom_range(0, 2) != 0);
            exec_done = ($urandom_range(0, 1) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 39))
                0:       pc_next = m_pc + 32'($urandom_range(1, 3));
                1, 2, 3: pc_next = {r[31:2] ^ 30'h2AAA_AAAA, 2'b00};
                4:       pc_next = 32'hFFFF_FFFC;
                default: pc_next = m_pc + 32'd4;
            endcase
            tick();
        end

        mem_ack = 0; exec_done = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/insn_fetch_unit.md
Name: insn_fetch_unit

Overview:
- Multi-cycle instruction fetch and hold stage that sits directly upstream of the per-format control decoders (R/I/I-JALR/S/B/U/J).
- Owns the architectural PC and requests instructions from memory with a req/ack handshake.
- Latches the fetched word into INSN and holds it stable for the whole execute phase.
- Pre-decodes the opcode into an instruction class; the control unit uses the class to select which decoder's outputs drive the datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, maximum wait for mem_ack. Only used when FETCH_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- CLK  in  1  processor clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- mem_addr  out  32  fetch address; equals pc while mem_req is high.
- mem_req  out  1  fetch request.
- mem_ack  in  1  memory has mem_rdata valid this cycle.
- mem_rdata  in  32  fetched instruction word.
- INSN  out  32  latched instruction fed to all decoders.
- insn_valid  out  1  INSN is stable and executing.
- insn_class  out  4  pre-decoded class (see package).
- pc  out  32  address of the current instruction.
- pc_next  in  32  next PC from the PC ALU (pc+4, branch or JAL/JALR target).
- exec_done  in  1  datapath has finished the current instruction.
- stall  in  1  holds the EXEC state even if exec_done is high.
- halted  out  1  unit is stopped in HALT.
- fault  out  2  halt cause: 0 none, 1 illegal opcode, 2 misaligned pc_next, 3 bus timeout.

Behaviour:
- Reset (RST high, asynchronous, any state):
  - state=REQ, pc=RESET_PC, INSN=32'h0000_0013 (NOP), insn_valid=0, mem_req=0, halted=0, fault=0, timeout counter=0.
  - mem_req must drop in the same cycle RST rises; it is not held until the next edge.
- States: REQ, EXEC, HALT (2-bit encoding).
- REQ:
  - mem_req=1 and mem_addr=pc, combinationally decoded from the state.
  - On a rising edge with mem_ack=1: INSN<=mem_rdata.
    - Pre-decoded class is ILLEGAL -> HALT with fault=1, insn_valid stays 0.
    - Otherwise -> EXEC with insn_valid=1.
  - mem_ack is ignored outside REQ.
- EXEC:
  - mem_req=0, insn_valid=1; INSN and pc held constant.
  - exec_done=1 and stall=0 on an edge:
    - pc_next[1:0] != 0 -> HALT with fault=2; pc is not updated.
    - Otherwise pc<=pc_next, insn_valid<=0, -> REQ.
  - stall=1 always wins over exec_done.
- HALT:
  - mem_req=0, insn_valid=0, halted=1; fault is held.
  - Only RST exits HALT.
- Latency: minimum 2 cycles per instruction (1 REQ with immediate ack, 1 EXEC). Each extra cycle of mem_ack delay adds one cycle.
- insn_class is a combinational function of INSN[6:0] and is valid whenever insn_valid=1.
  - opcode[1:0] != 2'b11 or an unlisted opcode -> ILLEGAL.
- pc wrap-around: pc_next=32'hFFFF_FFFC followed by +4 wraps to 0. No special handling.
- No fetch is ever issued while insn_valid=1, so INSN never changes mid-execute.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering REQ and increments each REQ cycle without mem_ack.
  - On the edge where the count reaches TIMEOUT_CYCLES with no mem_ack -> HALT with fault=3.
  - An ack on that same edge takes priority over the timeout.
- Undefined: no counter is built; REQ waits indefinitely and fault=3 is never produced.

Decomposition:
- Shared package rv32i_pkg:
  - Opcode localparams: OP_LUI 7'b0110111, OP_AUIPC 7'b0010111, OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_BRANCH 7'b1100011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_IMM 7'b0010011, OP_REG 7'b0110011, OP_SYSTEM 7'b1110011.
  - insn_class codes 0..9 in the same order as the opcodes above; ILLEGAL=4'hF.
  - Fault codes and the NOP constant.
- The FSM state encoding stays local to insn_fetch_unit.
- Sub-module insn_predecode: purely combinational, INSN[6:0] -> insn_class. It is reusable by the control unit.

Test Plan:
- Reset then immediate ack with mem_rdata=32'h00000013: mem_addr=0 in cycle 1; next cycle insn_valid=1, INSN=32'h00000013, insn_class=OP_IMM code.
- Ack delayed 3 cycles: mem_req held high with mem_addr stable for 4 cycles; INSN latched only on the ack edge.
- JALR 32'h000080E7 executing with pc_next=32'h0000_0100 and exec_done=1 while stall=1 for 2 cycles: pc unchanged until stall drops, then pc=32'h100 and mem_addr=32'h100.
- pc_next=32'h0000_0102 on exec_done: HALT with fault=2, halted=1, mem_req stays 0 for 10+ cycles.
- mem_rdata=32'h00000000 (illegal opcode): HALT with fault=1, insn_valid never asserts.
- RST pulsed mid-REQ (between edges): mem_req falls during RST; after release pc=RESET_PC. With FETCH_TIMEOUT_EN and no ack: fault=3 after exactly 16 REQ cycles.
